p20_time_set_ctrl: RTL and testbench



---
 rtl/p20_time_set_ctrl.sv | 114 +++++++++++
 tb/tb_p20_time_set_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/p20_time_set_ctrl.sv
// p20_time_set_ctrl: 24h clock set by two debounced buttons; TIME_SET_AUTOREPEAT_EN adds hold-to-repeat
module p20_time_set_ctrl #(
  parameter int TICK_DIV          = 25175000,
  parameter int DEBOUNCE_CYC      = 65536,
  parameter int REPEAT_DELAY_CYC  = 12587500,
  parameter int REPEAT_PERIOD_CYC = 3146875
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hour_btn,
  input  logic       minute_btn,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       sec_tick,
  output logic       setting
);
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  // buttons are indexed [1]=hour, [0]=minute; pending flags are {hour, minute, tick}
  logic [1:0] s1_q, s1_d, s2_q, s2_d, db_q, db_d, dbp_q, dbp_d, rise, rep;
  logic [DW-1:0] dcnt_q [2];
  logic [DW-1:0] dcnt_d [2];
  logic [2:0] pend_q, pend_d, grant;
  logic [PW-1:0] presc_q, presc_d;
  logic [4:0] hours_q, hours_d;
  logic [5:0] minutes_q, minutes_d, seconds_q, seconds_d;
  logic tick_q, tick_d, wrap, s_wrap, m_wrap, h_wrap;
  // synchronize, debounce and detect the press edge of both buttons
  always_comb begin
    s1_d = {hour_btn, minute_btn};
    s2_d = s1_q;
    dbp_d = db_q;
    rise = db_q & ~dbp_q;
    for (int i = 0; i < 2; i++) begin
      dcnt_d[i] = (s2_q[i] == db_q[i] || dcnt_q[i] == DW'(DEBOUNCE_CYC - 1)) ? '0 : dcnt_q[i] + 1'b1;
      db_d[i] = (s2_q[i] != db_q[i] && dcnt_q[i] == DW'(DEBOUNCE_CYC - 1)) ? s2_q[i] : db_q[i];
    end
  end
  // grant one pending source per cycle (tick > minute > hour) and apply its update
  always_comb begin
    grant = pend_q[0] ? 3'b001 : pend_q[1] ? 3'b010 : pend_q[2] ? 3'b100 : 3'b000;
    wrap = presc_q == PW'(TICK_DIV - 1);
    s_wrap = seconds_q == 6'd59;
    m_wrap = minutes_q == 6'd59;
    h_wrap = hours_q == 5'd23;
    presc_d = (grant[1] || wrap) ? '0 : presc_q + 1'b1;
    pend_d = (pend_q & ~grant) | {rise | rep, wrap};
    seconds_d = grant[0] ? (s_wrap ? '0 : seconds_q + 6'd1) : grant[1] ? '0 : seconds_q;
    minutes_d = (grant[1] || (grant[0] && s_wrap)) ? (m_wrap ? '0 : minutes_q + 6'd1) : minutes_q;
    hours_d = (grant[2] || (grant[0] && s_wrap && m_wrap)) ? (h_wrap ? '0 : hours_q + 5'd1) : hours_q;
    tick_d = grant[0];
  end
  // state registers, all cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      db_q <= '0;
      dbp_q <= '0;
      dcnt_q <= '{default: '0};
      pend_q <= '0;
      presc_q <= '0;
      hours_q <= '0;
      minutes_q <= '0;
      seconds_q <= '0;
      tick_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      db_q <= db_d;
      dbp_q <= dbp_d;
      dcnt_q <= dcnt_d;
      pend_q <= pend_d;
      presc_q <= presc_d;
      hours_q <= hours_d;
      minutes_q <= minutes_d;
      seconds_q <= seconds_d;
      tick_q <= tick_d;
    end
  end
`ifdef TIME_SET_AUTOREPEAT_EN
  localparam int RMAX = REPEAT_DELAY_CYC > REPEAT_PERIOD_CYC ? REPEAT_DELAY_CYC : REPEAT_PERIOD_CYC;
  localparam int RW = $clog2(RMAX + 1);
  logic [RW-1:0] rcnt_q [2];
  logic [RW-1:0] rcnt_d [2];
  logic [1:0] first_q, first_d;
  // while held, re-request after the initial delay and then every period
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rep[i] = db_q[i] & ~rise[i] & (rcnt_q[i] == (first_q[i] ? RW'(REPEAT_DELAY_CYC - 1) : RW'(REPEAT_PERIOD_CYC - 1)));
      rcnt_d[i] = (rise[i] || rep[i]) ? '0 : db_q[i] ? rcnt_q[i] + 1'b1 : rcnt_q[i];
      first_d[i] = rise[i] | (first_q[i] & ~rep[i]);
    end
  end
  // repeat counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt_q <= '{default: '0};
      first_q <= '0;
    end else begin
      rcnt_q <= rcnt_d;
      first_q <= first_d;
    end
  end
`else
  assign rep = '0;
`endif
  assign hours = hours_q;
  assign minutes = minutes_q;
  assign seconds = seconds_q;
  assign sec_tick = tick_q;
  assign setting = |db_q;
endmodule

// File: tb/tb_p20_time_set_ctrl.sv
// tb_p20_time_set_ctrl: vector table, directed corner sequences and random buttons against a reference model
module tb_p20_time_set_ctrl;
  localparam int TD = 10, DC = 4, RD = 20, RP = 8;
  logic clk = 1'b0, rst = 1'b1, hour_btn = 1'b0, minute_btn = 1'b0;
  logic [4:0] hours;
  logic [5:0] minutes, seconds;
  logic sec_tick, setting;
  int pass_cnt = 0, chk_cnt = 0;

  p20_time_set_ctrl #(.TICK_DIV(TD), .DEBOUNCE_CYC(DC), .REPEAT_DELAY_CYC(RD), .REPEAT_PERIOD_CYC(RP)) dut (
    .clk(clk), .rst(rst), .hour_btn(hour_btn), .minute_btn(minute_btn),
    .hours(hours), .minutes(minutes), .seconds(seconds), .sec_tick(sec_tick), .setting(setting)
  );

  always #5 clk = ~clk;

  // reference model: buttons 0=hour 1=minute; requests 0=tick 1=minute 2=hour
  bit hist [2][8];
  bit mdb [2];
  bit mrose [2];
  bit mpend [3];
  int mel [2];
  int mpc, mh, mm, ms;
  bit mtick;

  typedef struct { logic h; logic m; int hold; int eh; int em; } vec_t;
  vec_t tbl [7];

  task automatic chk(input string nm, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic model_step();
    bit g [3];
    bit set [3];
    bit raw [2];
    bit wrap, same, rep;
    int tot;
    raw[0] = hour_btn;
    raw[1] = minute_btn;
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int j = 0; j < 8; j++) hist[b][j] = 0;
        mdb[b] = 0; mrose[b] = 0; mel[b] = 0;
      end
      for (int k = 0; k < 3; k++) mpend[k] = 0;
      mpc = 0; mh = 0; mm = 0; ms = 0; mtick = 0;
      return;
    end
    g[0] = mpend[0];
    g[1] = !g[0] && mpend[1];
    g[2] = !g[0] && !g[1] && mpend[2];
    mtick = g[0];
    if (g[0]) begin
      tot = (mh * 3600 + mm * 60 + ms + 1) % 86400;
      mh = tot / 3600; mm = (tot / 60) % 60; ms = tot % 60;
    end
    if (g[1]) begin mm = (mm + 1) % 60; ms = 0; end
    if (g[2]) mh = (mh + 1) % 24;
    wrap = mpc == TD - 1;
    mpc = g[1] ? 0 : (mpc + 1) % TD;
    set[0] = wrap;
    for (int b = 0; b < 2; b++) begin
      rep = 0;
`ifdef TIME_SET_AUTOREPEAT_EN
      if (!mrose[b] && mdb[b]) begin
        mel[b]++;
        rep = (mel[b] == RD) || (mel[b] > RD && (mel[b] - RD) % RP == 0);
      end
      if (mrose[b]) mel[b] = 0;
`endif
      set[2 - b] = mrose[b] || rep;
    end
    for (int k = 0; k < 3; k++) mpend[k] = (mpend[k] && !g[k]) || set[k];
    for (int b = 0; b < 2; b++) begin
      same = 1;
      for (int j = 2; j <= DC; j++) if (hist[b][j] != hist[b][1]) same = 0;
      mrose[b] = 0;
      if (same && hist[b][1] != mdb[b]) begin mdb[b] = hist[b][1]; mrose[b] = mdb[b]; end
      for (int j = 7; j > 0; j--) hist[b][j] = hist[b][j - 1];
      hist[b][0] = raw[b];
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      model_step();
      @(posedge clk);
      #1;
      chk("hours", hours, mh);
      chk("minutes", minutes, mm);
      chk("seconds", seconds, ms);
      chk("sec_tick", sec_tick, mtick);
      chk("setting", setting, mdb[0] | mdb[1]);
    end
  endtask

  task automatic do_reset();
    rst = 1; hour_btn = 0; minute_btn = 0;
    cyc(2);
    rst = 0;
  endtask

  task automatic press(input logic h, input logic m, input int hold, input int rel);
    hour_btn = h; minute_btn = m;
    cyc(hold);
    hour_btn = 0; minute_btn = 0;
    cyc(rel);
  endtask

  task automatic wait_tick();
    bit seen = 0;
    for (int i = 0; i < 3 * TD && !seen; i++) begin cyc(1); seen = sec_tick; end
    chk("tick_wait", seen, 1);
  endtask

  initial begin
    int n, last, gap_bad, m0, s0;
    bit found;
    int rem [2];
    logic lvl [2];
    tbl[0] = '{1'b1, 1'b0, 6, 1, 0};
    tbl[1] = '{1'b0, 1'b1, 6, 1, 1};
    tbl[2] = '{1'b1, 1'b1, 6, 2, 2};
    tbl[3] = '{1'b1, 1'b0, 3, 2, 2};
    tbl[4] = '{1'b0, 1'b1, 4, 2, 3};
    tbl[5] = '{1'b0, 1'b1, 3, 2, 3};
    tbl[6] = '{1'b1, 1'b0, 4, 3, 3};

    cyc(3);
    chk("rst_hours", hours, 0);
    chk("rst_minutes", minutes, 0);
    chk("rst_seconds", seconds, 0);
    chk("rst_tick", sec_tick, 0);
    chk("rst_setting", setting, 0);
    rst = 0;

    n = 0; last = 0; gap_bad = 0;
    for (int c = 1; c <= TD * 60 + 1; c++) begin
      cyc(1);
      if (sec_tick) begin
        if (n > 0 && c - last != TD) gap_bad++;
        n++; last = c;
      end
    end
    chk("idle_tick_count", n, 60);
    chk("idle_tick_gaps", gap_bad, 0);
    chk("idle_hours", hours, 0);
    chk("idle_minutes", minutes, 1);
    chk("idle_seconds", seconds, 0);

    do_reset();
    for (int i = 0; i < 7; i++) begin
      press(tbl[i].h, tbl[i].m, tbl[i].hold, 10);
      chk($sformatf("tbl%0d_hours", i), hours, tbl[i].eh);
      chk($sformatf("tbl%0d_minutes", i), minutes, tbl[i].em);
    end

    do_reset();
    for (int i = 0; i < 23; i++) press(1, 0, 6, 10);
    for (int i = 0; i < 59; i++) press(0, 1, 6, 10);
    chk("preset_hours", hours, 23);
    chk("preset_minutes", minutes, 59);
    found = 0;
    for (int i = 0; i < 80 * TD && !found; i++) begin cyc(1); found = seconds == 59; end
    chk("preset_sec59", found, 1);
    wait_tick();
    chk("wrap_hours", hours, 0);
    chk("wrap_minutes", minutes, 0);
    chk("wrap_seconds", seconds, 0);

    wait_tick();
    cyc(1);
    minute_btn = 1; cyc(1);
    minute_btn = 0; cyc(1);
    minute_btn = 1;
    m0 = mm;
    cyc(7);
    chk("bounce_early", minutes, m0);
    cyc(1);
    chk("bounce_on_time", minutes, (m0 + 1) % 60);
    chk("bounce_sec_zero", seconds, 0);
    cyc(6);
    minute_btn = 0;
    cyc(10);
    chk("bounce_single", minutes, (m0 + 1) % 60);

    wait_tick();
    cyc(2);
    minute_btn = 1; cyc(6);
    minute_btn = 0; cyc(1);
    s0 = ms; m0 = mm;
    cyc(1);
    chk("coll_tick_first", sec_tick, 1);
    chk("coll_tick_sec", seconds, (s0 + 1) % 60);
    chk("coll_min_wait", minutes, m0);
    cyc(1);
    chk("coll_min_next", minutes, (m0 + 1) % 60);
    chk("coll_min_sec0", seconds, 0);
    chk("coll_tick_off", sec_tick, 0);

    do_reset();
    for (int i = 0; i < 22; i++) press(1, 0, 6, 10);
    chk("hold_start_hours", hours, 22);
    hour_btn = 1; cyc(60);
    hour_btn = 0; cyc(20);
`ifdef TIME_SET_AUTOREPEAT_EN
    chk("hold_end_hours", hours, 4);
`else
    chk("hold_end_hours", hours, 23);
`endif

    do_reset();
    hour_btn = 1; cyc(5);
    rst = 1; hour_btn = 0; cyc(2);
    chk("midrst_hours", hours, 0);
    chk("midrst_minutes", minutes, 0);
    chk("midrst_seconds", seconds, 0);
    chk("midrst_tick", sec_tick, 0);
    chk("midrst_setting", setting, 0);
    rst = 0; cyc(30);
    chk("midrst_no_inc", hours, 0);

    rst = 1; hour_btn = 1; cyc(3);
    rst = 0; cyc(7);
    chk("held_rst_before", hours, 0);
    cyc(1);
    chk("held_rst_press", hours, 1);
    hour_btn = 0; cyc(10);

    do_reset();
    rem[0] = 0; rem[1] = 0; lvl[0] = 0; lvl[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 2; b++) begin
        if (rem[b] == 0) begin
          lvl[b] = 1'($urandom_range(0, 1));
          rem[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 40);
        end else rem[b]--;
      end
      hour_btn = lvl[0]; minute_btn = lvl[1];
      rst = $urandom_range(0, 599) == 0;
      cyc(1);
    end
    rst = 0; hour_btn = 0; minute_btn = 0;
    cyc(20);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
